// File: rtl/coproc_mem_sweeper.sv
// coproc_mem_sweeper
// Walks a range of coprocessor data-memory words, either reading each word
// out on a valid/ready stream (dump) or writing a fill value into each word
// (clear). Each core access is held for WAIT_CYCLES cycles.
//
// Ports
//   clk, reset (async, active low)
//   cmd_*      : command handshake, op, start index, word count, fill value
//   out_*      : dump stream (address, data, last) with valid/ready
//   busy, done : status, done is a one-cycle completion pulse
//   coprocessorIO* : address / control / write data to the core, read data back
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// ISSUE  | core access in progress for the current word
// EMIT   | dumped word presented on out_*, waiting for out_ready
// FINISH | one-cycle done pulse
module coproc_mem_sweeper #(
   parameter int N           = 64,
   parameter int WAIT_CYCLES = 2,
   parameter int WORDS       = 4096
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_op,
   input  logic [11:0]   cmd_start,
   input  logic [12:0]   cmd_count,
   input  logic [N-1:0]  cmd_fill,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [14:0]   out_addr,
   output logic [N-1:0]  out_data,
   output logic          out_last,
   output logic          busy,
   output logic          done,
   output logic [14:0]   coprocessorIOAddr,
   output logic [4:0]    coprocessorIOControl,
   output logic [N-1:0]  coprocessorIODataOut,
   input  logic [N-1:0]  coprocessorIODataIn
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ISSUE  = 2'd1;
   localparam logic [1:0] S_EMIT   = 2'd2;
   localparam logic [1:0] S_FINISH = 2'd3;

   localparam int              WW        = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [WW-1:0]   WAIT_LOAD = WW'(WAIT_CYCLES - 1);
   localparam logic [11:0]     LAST_IDX  = 12'(WORDS - 1);
   localparam logic [12:0]     MAX_COUNT = 13'd4096;
   localparam logic [4:0]      CTRL_RD   = 5'b00100;
   localparam logic [4:0]      CTRL_WR   = 5'b00010;

   logic [1:0]    state_q, state_d;
   logic          ready_q, ready_d;
   logic          op_q, op_d;
   logic [12:0]   count_q, count_d;
   logic [N-1:0]  fill_q, fill_d;
   logic [11:0]   idx_q, idx_d;
   logic [12:0]   cnt_q, cnt_d;
   logic [WW-1:0] wait_q, wait_d;
   logic [N-1:0]  data_q, data_d;

   logic [12:0]   count_clamped;
   logic [11:0]   idx_next;
   logic [12:0]   cnt_inc;

   assign count_clamped = (cmd_count > MAX_COUNT) ? MAX_COUNT : cmd_count;
   assign idx_next      = (idx_q == LAST_IDX) ? 12'd0 : idx_q + 12'd1;
   assign cnt_inc       = cnt_q + 13'd1;

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      count_d = count_q;
      fill_d  = fill_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      wait_d  = wait_q;
      data_d  = data_q;
      case (state_q)
         S_IDLE: begin
            // ready_q stays low until the first edge after reset release
            if (cmd_valid && ready_q) begin
               op_d    = cmd_op;
               count_d = count_clamped;
               fill_d  = cmd_fill;
               idx_d   = 12'({20'd0, cmd_start} % 32'(WORDS));
               cnt_d   = 13'd0;
               wait_d  = WAIT_LOAD;
               state_d = (count_clamped == 13'd0) ? S_FINISH : S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (wait_q == '0) begin
               cnt_d = cnt_inc;
               if (!op_q) begin
                  data_d  = coprocessorIODataIn;
                  state_d = S_EMIT;
               end else if (cnt_inc == count_q) begin
                  state_d = S_FINISH;
               end else begin
                  idx_d   = idx_next;
                  wait_d  = WAIT_LOAD;
                  state_d = S_ISSUE;
               end
            end else begin
               wait_d = wait_q - WW'(1);
            end
         end
         S_EMIT: begin
            if (out_ready) begin
               if (cnt_q == count_q) begin
                  state_d = S_FINISH;
               end else begin
                  idx_d   = idx_next;
                  wait_d  = WAIT_LOAD;
                  state_d = S_ISSUE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         ready_q <= 1'b0;
         op_q    <= 1'b0;
         count_q <= '0;
         fill_q  <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         wait_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
         op_q    <= op_d;
         count_q <= count_d;
         fill_q  <= fill_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         wait_q  <= wait_d;
         data_q  <= data_d;
      end
   end

   // idx_q only advances on entry to the next word's ISSUE, so the core
   // address and out_addr both hold through EMIT and FINISH.
   assign cmd_ready            = ready_q;
   assign out_valid            = (state_q == S_EMIT);
   assign out_addr             = {idx_q, 3'b000};
   assign out_data             = data_q;
   assign out_last             = (state_q == S_EMIT) && (cnt_q == count_q);
   assign busy                 = (state_q != S_IDLE);
   assign done                 = (state_q == S_FINISH);
   assign coprocessorIOAddr    = {idx_q, 3'b000};
   assign coprocessorIOControl = (state_q == S_ISSUE) ? (op_q ? CTRL_WR : CTRL_RD) : 5'b00000;
   assign coprocessorIODataOut = fill_q;

endmodule

// File: tb/tb_coproc_mem_sweeper.sv
`timescale 1ns/1ps
module tb_coproc_mem_sweeper;

   localparam int N     = 64;
   localparam int W     = 2;
   localparam int WORDS = 4096;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          cmd_valid, cmd_ready, cmd_op;
   logic [11:0]   cmd_start;
   logic [12:0]   cmd_count;
   logic [N-1:0]  cmd_fill;
   logic          out_valid, out_ready, out_last, busy, done;
   logic [14:0]   out_addr, coprocessorIOAddr;
   logic [N-1:0]  out_data, coprocessorIODataOut, coprocessorIODataIn;
   logic [4:0]    coprocessorIOControl;

   coproc_mem_sweeper #(.N(N), .WAIT_CYCLES(W), .WORDS(WORDS)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_start(cmd_start), .cmd_count(cmd_count), .cmd_fill(cmd_fill),
      .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
      .out_data(out_data), .out_last(out_last), .busy(busy), .done(done),
      .coprocessorIOAddr(coprocessorIOAddr), .coprocessorIOControl(coprocessorIOControl),
      .coprocessorIODataOut(coprocessorIODataOut), .coprocessorIODataIn(coprocessorIODataIn)
   );

   always #5 clk = ~clk;

   typedef struct packed { logic [4:0] ctrl; logic [14:0] addr; logic [63:0] dout; } acc_t;
   typedef struct packed { logic [14:0] addr; logic [63:0] data; logic last; } out_t;

   acc_t        acc_q[$];
   out_t        out_q[$];
   logic [63:0] mem     [WORDS];
   logic [63:0] ref_mem [WORDS];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          rdy_mode = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic outs_nonzero();
      return |{cmd_ready, out_valid, out_addr, out_data, out_last, busy, done,
               coprocessorIOAddr, coprocessorIOControl, coprocessorIODataOut};
   endfunction

   // core data memory: writes land on any cycle the core sees a write access
   assign coprocessorIODataIn = mem[coprocessorIOAddr[14:3]];
   initial begin : core_mem
      for (int i = 0; i < WORDS; i++) mem[i] = 64'(i + 32'h100);
      forever begin
         @(negedge clk);
         if (reset && coprocessorIOControl == 5'b00010)
            mem[coprocessorIOAddr[14:3]] = coprocessorIODataOut;
      end
   end

   // consumer: 0 = always ready, 1 = random, 2 = five stalled cycles per word
   initial begin : rdy_drv
      int stall;
      stall = 0;
      out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: begin
               if (out_valid) begin
                  if (stall < 5) begin out_ready = 1'b0; stall++; end
                  else begin out_ready = 1'b1; stall = 0; end
               end else begin
                  out_ready = 1'b0;
                  stall = 0;
               end
            end
         endcase
      end
   end

   // monitor: core accesses and dump words against the scoreboard queues
   initial begin : mon
      logic        in_run, p_valid, p_ready, p_last;
      logic [4:0]  r_ctrl;
      logic [14:0] r_addr, p_addr;
      logic [63:0] r_dout, p_data;
      int          r_len;
      acc_t        ea;
      out_t        eo;
      in_run = 1'b0; p_valid = 1'b0; p_ready = 1'b0; p_last = 1'b0;
      r_ctrl = '0; r_addr = '0; r_dout = '0; r_len = 0; p_addr = '0; p_data = '0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            in_run  = 1'b0;
            p_valid = 1'b0;
         end else begin
            if (coprocessorIOControl != 5'b00000) begin
               if (in_run && coprocessorIOControl == r_ctrl && coprocessorIOAddr == r_addr) begin
                  r_len++;
                  check("acc_dout_stable", coprocessorIODataOut, r_dout);
               end else begin
                  if (in_run) check("acc_len", 64'(r_len), 64'(W));
                  if (acc_q.size() == 0) begin
                     check("acc_unexpected", 64'(coprocessorIOControl), 64'(0));
                  end else begin
                     ea = acc_q.pop_front();
                     check("acc_ctrl", 64'(coprocessorIOControl), 64'(ea.ctrl));
                     check("acc_addr", 64'(coprocessorIOAddr), 64'(ea.addr));
                     check("acc_dout", coprocessorIODataOut, ea.dout);
                  end
                  in_run = 1'b1;
                  r_ctrl = coprocessorIOControl;
                  r_addr = coprocessorIOAddr;
                  r_dout = coprocessorIODataOut;
                  r_len  = 1;
               end
            end else begin
               if (in_run) check("acc_len", 64'(r_len), 64'(W));
               in_run = 1'b0;
            end

            if (p_valid && !p_ready) begin
               check("out_hold_valid", 64'(out_valid), 64'(1));
               check("out_hold_addr", 64'(out_addr), 64'(p_addr));
               check("out_hold_data", out_data, p_data);
               check("out_hold_last", 64'(out_last), 64'(p_last));
            end
            if (out_valid) begin
               check("ctrl_zero_in_emit", 64'(coprocessorIOControl), 64'(0));
               if (out_ready) begin
                  if (out_q.size() == 0) begin
                     check("out_unexpected", 64'(out_valid), 64'(0));
                  end else begin
                     eo = out_q.pop_front();
                     check("out_addr", 64'(out_addr), 64'(eo.addr));
                     check("out_data", out_data, eo.data);
                     check("out_last", 64'(out_last), 64'(eo.last));
                  end
               end
            end
            p_valid = out_valid; p_ready = out_ready;
            p_addr  = out_addr;  p_data  = out_data; p_last = out_last;
         end
      end
   end

   // reference: word k sits at index (start+k) mod WORDS; count clamps at 4096
   task automatic expect_sweep(input logic op, input logic [11:0] start, input int cnt,
                               input logic [63:0] fill);
      acc_t a;
      out_t o;
      int   idx;
      for (int k = 0; k < cnt; k++) begin
         idx    = (int'(start) + k) % WORDS;
         a.ctrl = op ? 5'b00010 : 5'b00100;
         a.addr = 15'(idx * 8);
         a.dout = fill;
         acc_q.push_back(a);
         if (op) begin
            ref_mem[idx] = fill;
         end else begin
            o.addr = 15'(idx * 8);
            o.data = ref_mem[idx];
            o.last = (k == cnt - 1);
            out_q.push_back(o);
         end
      end
   endtask

   task automatic run_cmd(input logic op, input logic [11:0] start, input logic [12:0] count,
                          input logic [63:0] fill, input int exp_lat);
      int cnt, lat, budget;
      cnt = (count > 13'd4096) ? 4096 : int'(count);
      expect_sweep(op, start, cnt, fill);
      budget = 0;
      @(negedge clk);
      while (!cmd_ready && budget < 100) begin @(negedge clk); budget++; end
      check("cmd_ready_idle", 64'(cmd_ready), 64'(1));
      cmd_valid = 1'b1; cmd_op = op; cmd_start = start; cmd_count = count; cmd_fill = fill;
      @(posedge clk); #1;
      // scramble the command bus: the latched copy must be used
      cmd_valid = 1'b0;
      cmd_op    = 1'($urandom);
      cmd_start = 12'($urandom);
      cmd_count = 13'($urandom);
      cmd_fill  = {$urandom, $urandom};
      check("busy_after_accept", 64'(busy), 64'(1));
      check("ready_low_after_accept", 64'(cmd_ready), 64'(0));
      lat = 0;
      budget = cnt * 40 + 20;
      while (!done && lat < budget) begin @(posedge clk); #1; lat++; end
      check("done_seen", 64'(done), 64'(1));
      if (exp_lat >= 0) check("done_latency", 64'(lat), 64'(exp_lat));
      @(posedge clk); #1;
      check("done_one_cycle", 64'(done), 64'(0));
      check("busy_low_idle", 64'(busy), 64'(0));
      check("ready_back", 64'(cmd_ready), 64'(1));
   endtask

   initial begin : main
      logic [63:0] fill;
      logic        op;
      logic [11:0] start;
      logic [12:0] count;
      int          mode, exp, lat, bad;
      cmd_valid = 1'b0; cmd_op = 1'b0; cmd_start = '0; cmd_count = '0; cmd_fill = '0;
      for (int i = 0; i < WORDS; i++) ref_mem[i] = 64'(i + 32'h100);

      repeat (3) @(posedge clk);
      #1;
      check("rst_outputs_zero", 64'(outs_nonzero()), 64'(0));
      check("rst_ready_low", 64'(cmd_ready), 64'(0));
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;
      check("ready_after_rst", 64'(cmd_ready), 64'(1));
      check("busy_after_rst", 64'(busy), 64'(0));

      run_cmd(1'b0, 12'd0, 13'd4, 64'd0, 4 * (W + 1));
      run_cmd(1'b1, 12'd4094, 13'd3, 64'd0, 3 * W);

      rdy_mode = 2;
      run_cmd(1'b0, 12'd10, 13'd2, 64'hA5A5_0000_1234_5678, 2 * (W + 6));
      rdy_mode = 0;

      run_cmd(1'b1, 12'd5, 13'd0, 64'hDEAD_BEEF_0000_0001, 0);
      run_cmd(1'b0, 12'd7, 13'd0, 64'h1, 0);

      // reset in the middle of the third word of an 8-word clear
      fill = {$urandom, $urandom} | 64'h1;
      expect_sweep(1'b1, 12'd100, 3, fill);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 1'b1; cmd_start = 12'd100; cmd_count = 13'd8; cmd_fill = fill;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      lat = 0;
      while (!(coprocessorIOControl == 5'b00010 && coprocessorIOAddr == 15'd816) && lat < 50) begin
         @(posedge clk); #1; lat++;
      end
      check("rst_test_word2_reached", 64'(coprocessorIOAddr), 64'(816));
      @(posedge clk); #2;
      reset = 1'b0;
      #1;
      check("async_rst_outputs_zero", 64'(outs_nonzero()), 64'(0));
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;
      check("post_rst_ready", 64'(cmd_ready), 64'(1));
      check("post_rst_busy", 64'(busy), 64'(0));
      repeat (4) @(posedge clk);
      #1;
      check("no_resume_busy", 64'(busy), 64'(0));
      check("no_resume_ctrl", 64'(coprocessorIOControl), 64'(0));
      bad = 0;
      for (int i = 103; i < 108; i++) if (mem[i] !== ref_mem[i]) bad++;
      check("rst_mem_untouched", 64'(bad), 64'(0));
      run_cmd(1'b0, 12'd100, 13'd8, 64'd0, 8 * (W + 1));

      for (int it = 0; it < 20; it++) begin
         op    = 1'($urandom_range(0, 1));
         start = ($urandom_range(0, 2) == 0) ? 12'(4090 + $urandom_range(0, 5))
                                             : 12'($urandom_range(0, 4095));
         count = 13'($urandom_range(0, 12));
         fill  = {$urandom, $urandom};
         mode  = int'($urandom_range(0, 1));
         rdy_mode = mode;
         if (count == 13'd0)   exp = 0;
         else if (op)          exp = int'(count) * W;
         else if (mode == 0)   exp = int'(count) * (W + 1);
         else                  exp = -1;
         run_cmd(op, start, count, fill, exp);
      end
      rdy_mode = 0;

      bad = 0;
      for (int i = 0; i < WORDS; i++) if (mem[i] !== ref_mem[i]) bad++;
      check("mem_vs_model", 64'(bad), 64'(0));

      // full sweeps; the clear command count is above range and clamps to 4096
      run_cmd(1'b1, 12'd0, 13'd8191, 64'd0, 4096 * W);
      run_cmd(1'b0, 12'd0, 13'd4096, 64'h55, 4096 * (W + 1));

      repeat (5) @(posedge clk);
      #1;
      check("acc_queue_drained", 64'(acc_q.size()), 64'(0));
      check("out_queue_drained", 64'(out_q.size()), 64'(0));
      bad = 0;
      for (int i = 0; i < WORDS; i++) if (mem[i] !== ref_mem[i]) bad++;
      check("mem_vs_model_final", 64'(bad), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
